// File: rtl/fixp_acc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fixp_acc_pkg                                                               |
// | Shared width helpers and FSM state encoding for the fixp_acc datapath.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package fixp_acc_pkg;

    // ceil(log2(n)), never below 1 so single-entry configurations still get a usable field
    function automatic int clogb2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int ch_w(input int num_ch);
        return clogb2(num_ch);
    endfunction

    function automatic int cs_w(input int depth);
        return clogb2(depth);
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CARRY = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fastadder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fastadder                                                                  |
// | Unsigned W-bit adder with carry out in sum[W].                             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fastadder #(
    parameter int W = 128
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b};

endmodule
`default_nettype wire

// File: rtl/fixp_acc_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fixp_acc_mc                                                                |
// | Multi-channel segmented super-accumulator with rippling carry and a        |
// | one-entry clear/readout result buffer.                                     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fixp_acc_mc
    import fixp_acc_pkg::*;
#(
    parameter  int NUM_CH   = 4,
    parameter  int DEPTH    = 32,
    parameter  int SEG_W    = 128,
    parameter  int SEG_STEP = 64,
    localparam int CH_W     = ch_w(NUM_CH),
    localparam int CS_W     = cs_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH_W-1:0]  in_ch,
    input  logic             in_sign,
    input  logic [CS_W-1:0]  in_seg,
    input  logic [SEG_W-1:0] in_data,
    output logic             add_event,
    input  logic             clr_valid,
    output logic             clr_ready,
    input  logic [CH_W-1:0]  clr_ch,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CH_W-1:0]  res_ch,
    output logic [SEG_W-1:0] res_pos_hi,
    output logic [SEG_W-1:0] res_pos_lo,
    output logic [SEG_W-1:0] res_neg_hi,
    output logic [SEG_W-1:0] res_neg_lo,
    output logic [CS_W-1:0]  res_max_p,
    output logic [CS_W-1:0]  res_max_n,
    output logic             res_ovf
);

    localparam logic [CS_W-1:0]  c_last_seg = CS_W'(DEPTH - 1);
    localparam logic [SEG_W-1:0] c_carry_in = SEG_W'(1) << SEG_STEP;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [SEG_W-1:0] pos_hi;
        logic [SEG_W-1:0] pos_lo;
        logic [SEG_W-1:0] neg_hi;
        logic [SEG_W-1:0] neg_lo;
        logic [CS_W-1:0]  max_p;
        logic [CS_W-1:0]  max_n;
        logic             ovf;
    } res_t;

    logic [SEG_W-1:0] r_seg [NUM_CH][2][DEPTH];
    logic [CS_W-1:0]  r_max [NUM_CH][2];
    logic [1:0]       r_ovf [NUM_CH];

    state_t           r_state;
    state_t           w_state_next;
    logic [CH_W-1:0]  r_cch;
    logic             r_csign;
    logic [CS_W-1:0]  r_ccs;
    res_t             r_res;
    logic             r_res_valid;
    logic             r_add_event;

    logic             w_clr_fire;
    logic             w_add_fire;
    logic             w_seg_we;
    logic             w_set_ovf;
    logic             w_carry_load;
    logic             w_carry_adv;
    logic [CS_W-1:0]  w_carry_idx;
    logic [CH_W-1:0]  w_wr_ch;
    logic             w_wr_sign;
    logic [CS_W-1:0]  w_wr_idx;
    logic [SEG_W-1:0] w_op_b;
    logic [SEG_W:0]   w_sum;
    logic [CS_W-1:0]  w_max_p;
    logic [CS_W-1:0]  w_max_n;
    res_t             w_res_next;

    // The single adder is shared: IDLE serves the incoming add, CARRY ripples into ccs+1
    assign w_carry_idx = r_ccs + CS_W'(1);
    assign w_wr_ch     = (r_state == ST_CARRY) ? r_cch       : in_ch;
    assign w_wr_sign   = (r_state == ST_CARRY) ? r_csign     : in_sign;
    assign w_wr_idx    = (r_state == ST_CARRY) ? w_carry_idx : in_seg;
    assign w_op_b      = (r_state == ST_CARRY) ? c_carry_in  : in_data;

    fastadder #(.W(SEG_W)) u_adder (
        .a   (r_seg[w_wr_ch][w_wr_sign][w_wr_idx]),
        .b   (w_op_b),
        .sum (w_sum)
    );

    assign clr_ready  = (r_state == ST_IDLE) & ~r_res_valid;
    assign w_clr_fire = clr_valid & clr_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        w_add_fire   = 1'b0;
        w_seg_we     = 1'b0;
        w_set_ovf    = 1'b0;
        w_carry_load = 1'b0;
        w_carry_adv  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A clear to the same channel takes priority; the add retries into the zeroed bank
                in_ready   = ~(w_clr_fire & (clr_ch == in_ch));
                w_add_fire = in_valid & in_ready;
                if (w_add_fire) begin
                    w_seg_we = 1'b1;
                    if (w_sum[SEG_W]) begin
                        if (in_seg == c_last_seg) begin
                            w_set_ovf = 1'b1;
                        end else begin
                            w_carry_load = 1'b1;
                            w_state_next = ST_CARRY;
                        end
                    end
                end
            end
            ST_CARRY: begin
                w_seg_we = 1'b1;
                if (w_sum[SEG_W] && (w_carry_idx != c_last_seg)) begin
                    w_carry_adv = 1'b1;
                end else begin
                    w_set_ovf    = w_sum[SEG_W];
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_max_p = r_max[clr_ch][0];
    assign w_max_n = r_max[clr_ch][1];

    always_comb begin
        w_res_next        = '0;
        w_res_next.ch     = clr_ch;
        w_res_next.max_p  = w_max_p;
        w_res_next.max_n  = w_max_n;
        w_res_next.ovf    = |r_ovf[clr_ch];
        w_res_next.pos_hi = r_seg[clr_ch][0][w_max_p];
        w_res_next.neg_hi = r_seg[clr_ch][1][w_max_n];
        if (w_max_p != '0) w_res_next.pos_lo = r_seg[clr_ch][0][w_max_p - CS_W'(1)];
        if (w_max_n != '0) w_res_next.neg_lo = r_seg[clr_ch][1][w_max_n - CS_W'(1)];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int s = 0; s < 2; s++) begin
                    for (int d = 0; d < DEPTH; d++) r_seg[c][s][d] <= '0;
                    r_max[c][s] <= '0;
                end
                r_ovf[c] <= '0;
            end
            r_cch       <= '0;
            r_csign     <= 1'b0;
            r_ccs       <= '0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_add_event <= 1'b0;
        end else begin
            r_add_event <= w_add_fire;
            if (w_seg_we) begin
                r_seg[w_wr_ch][w_wr_sign][w_wr_idx] <= w_sum[SEG_W-1:0];
                if (w_wr_idx > r_max[w_wr_ch][w_wr_sign]) r_max[w_wr_ch][w_wr_sign] <= w_wr_idx;
            end
            if (w_set_ovf) r_ovf[w_wr_ch][w_wr_sign] <= 1'b1;
            if (w_carry_load) begin
                r_cch   <= in_ch;
                r_csign <= in_sign;
                r_ccs   <= in_seg;
            end else if (w_carry_adv) begin
                r_ccs <= w_carry_idx;
            end
            // Any same-cycle add targets a different channel, so zeroing here cannot collide
            if (w_clr_fire) begin
                r_res       <= w_res_next;
                r_res_valid <= 1'b1;
                for (int s = 0; s < 2; s++) begin
                    for (int d = 0; d < DEPTH; d++) r_seg[clr_ch][s][d] <= '0;
                    r_max[clr_ch][s] <= '0;
                end
                r_ovf[clr_ch] <= '0;
            end else if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign add_event  = r_add_event;
    assign res_valid  = r_res_valid;
    assign res_ch     = r_res.ch;
    assign res_pos_hi = r_res.pos_hi;
    assign res_pos_lo = r_res.pos_lo;
    assign res_neg_hi = r_res.neg_hi;
    assign res_neg_lo = r_res.neg_lo;
    assign res_max_p  = r_res.max_p;
    assign res_max_n  = r_res.max_n;
    assign res_ovf    = r_res.ovf;

endmodule
`default_nettype wire
